// File: rtl/test_function_if.sv
// +----------------------------------------------------------------------------+
// | test_function_if : write-strobe monitor observation bus                    |
// | Carries the sampled write request and all monitor results.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface test_function_if #(
    parameter int CNT_W = 8,
    parameter int LEN_W = 4
) ();
    logic             i_WR;
    logic             o_WR_RISE;
    logic             o_WR_FALL;
    logic [CNT_W-1:0] o_WR_CNT;
    logic             o_CNT_OVF;
    logic [LEN_W-1:0] o_LAST_LEN;
    logic             o_BURST;

    // Monitor side
    modport slave (
        input  i_WR,
        output o_WR_RISE,
        output o_WR_FALL,
        output o_WR_CNT,
        output o_CNT_OVF,
        output o_LAST_LEN,
        output o_BURST
    );

    // Stimulus / observer side
    modport master (
        output i_WR,
        input  o_WR_RISE,
        input  o_WR_FALL,
        input  o_WR_CNT,
        input  o_CNT_OVF,
        input  o_LAST_LEN,
        input  o_BURST
    );
endinterface

`default_nettype wire

// File: rtl/test_function.sv
// +----------------------------------------------------------------------------+
// | test_function : write-strobe monitor                                       |
// | Registered rise/fall pulses, strobe count, last pulse length, burst flag.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module test_function #(
    parameter int CNT_W     = 8,
    parameter int LEN_W     = 4,
    parameter int BURST_LEN = 3
) (
    input  wire             i_CLK,
    input  wire             i_RST,
    test_function_if.slave  bus
);

    localparam logic [LEN_W-1:0] c_LEN_MAX   = {LEN_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [LEN_W-1:0] c_BURST_LEN = LEN_W'(BURST_LEN);

    logic             r_prev;
    logic [LEN_W-1:0] r_run;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic [LEN_W-1:0] r_last_len;
    logic             r_burst;

    logic             w_rise;
    logic             w_fall;
    logic             w_hold;

    assign w_rise = bus.i_WR  & ~r_prev;
    assign w_fall = ~bus.i_WR &  r_prev;
    assign w_hold = bus.i_WR  &  r_prev;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_prev     <= 1'b0;
            r_run      <= '0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_last_len <= '0;
            r_burst    <= 1'b0;
        end else begin
            r_prev <= bus.i_WR;
            r_rise <= w_rise;
            r_fall <= w_fall;
            if (w_rise) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == c_CNT_MAX) begin
                    r_ovf <= 1'b1;
                end
                r_run <= LEN_W'(1);
            end else if (w_hold) begin
                // Length saturates so over-long pulses still read as bursts
                if (r_run != c_LEN_MAX) begin
                    r_run <= r_run + 1'b1;
                end
            end else if (w_fall) begin
                r_last_len <= r_run;
                r_burst    <= (r_run >= c_BURST_LEN);
                r_run      <= '0;
            end
        end
    end

    assign bus.o_WR_RISE  = r_rise;
    assign bus.o_WR_FALL  = r_fall;
    assign bus.o_WR_CNT   = r_cnt;
    assign bus.o_CNT_OVF  = r_ovf;
    assign bus.o_LAST_LEN = r_last_len;
    assign bus.o_BURST    = r_burst;

endmodule

`default_nettype wire

// File: tb/tb_test_function.sv
// +----------------------------------------------------------------------------+
// | tb_test_function : self-checking bench for test_function                   |
// | Reference model pushes expected outputs; each edge pops and compares.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_test_function;

    localparam int c_CNT_W = 8;
    localparam int c_LEN_W = 4;
    localparam int c_BURST = 3;

    typedef struct packed {
        logic               rise;
        logic               fall;
        logic [c_CNT_W-1:0] cnt;
        logic               ovf;
        logic [c_LEN_W-1:0] len;
        logic               burst;
    } obs_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    obs_t sb[$];
    obs_t got;
    obs_t exp;

    // Reference model state
    logic m_prev;
    int   m_run;
    obs_t m_out;

    test_function_if #(.CNT_W(c_CNT_W), .LEN_W(c_LEN_W)) bus ();

    test_function #(
        .CNT_W     (c_CNT_W),
        .LEN_W     (c_LEN_W),
        .BURST_LEN (c_BURST)
    ) dut (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic obs_t sample();
        obs_t o;
        o.rise  = bus.o_WR_RISE;
        o.fall  = bus.o_WR_FALL;
        o.cnt   = bus.o_WR_CNT;
        o.ovf   = bus.o_CNT_OVF;
        o.len   = bus.o_LAST_LEN;
        o.burst = bus.o_BURST;
        return o;
    endfunction

    // Drive one edge, advance the model, queue its prediction, then settle past the edge
    task automatic drive(input logic wr, input logic r);
        bus.i_WR = wr;
        rst      = r;
        if (r) begin
            m_prev = 1'b0;
            m_run  = 0;
            m_out  = '0;
        end else begin
            m_out.rise = wr & ~m_prev;
            m_out.fall = ~wr & m_prev;
            if (m_out.rise) begin
                if (m_out.cnt == 8'hFF) m_out.ovf = 1'b1;
                m_out.cnt = m_out.cnt + 8'd1;
                m_run = 1;
            end else if (wr && m_prev) begin
                m_run = (m_run >= 15) ? 15 : m_run + 1;
            end else if (m_out.fall) begin
                m_out.len   = 4'(m_run);
                m_out.burst = (m_run >= c_BURST);
                m_run = 0;
            end
            m_prev = wr;
        end
        sb.push_back(m_out);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [1:0] seq [5] = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
        foreach (seq[i]) begin
            drive(seq[i][0], seq[i][1]);
            got = sample();
            exp = sb.pop_front();
            n_tests++;
            if (got !== exp || got !== '0) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %h required %h (all zero)", i, got, exp);
            end
        end
    endtask

    task automatic test_single();
        logic wr [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        foreach (wr[i]) begin
            drive(wr[i], 1'b0);
            got = sample();
            exp = sb.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL single[%0d]: got %h required %h", i, got, exp);
            end
        end
        n_tests++;
        if (got.cnt !== 8'd2 || got.len !== 4'd1 || got.burst !== 1'b0) begin
            n_fail++;
            $display("FAIL single_final: got cnt=%0d len=%0d burst=%b required cnt=2 len=1 burst=0",
                     got.cnt, got.len, got.burst);
        end
    endtask

    task automatic test_burst();
        logic wr [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        foreach (wr[i]) begin
            drive(wr[i], 1'b0);
            got = sample();
            exp = sb.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL burst[%0d]: got %h required %h", i, got, exp);
            end
        end
        n_tests++;
        if (got.cnt !== 8'd3 || got.len !== 4'd3 || got.burst !== 1'b1 || got.fall !== 1'b1) begin
            n_fail++;
            $display("FAIL burst_final: got cnt=%0d len=%0d burst=%b fall=%b required 3 3 1 1",
                     got.cnt, got.len, got.burst, got.fall);
        end
    endtask

    task automatic test_saturation();
        logic [c_CNT_W-1:0] cnt0;
        cnt0 = bus.o_WR_CNT;
        for (int i = 0; i < 21; i++) begin
            drive((i < 20), 1'b0);
            got = sample();
            exp = sb.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL saturation[%0d]: got %h required %h", i, got, exp);
            end
        end
        n_tests++;
        if (got.len !== 4'd15 || got.burst !== 1'b1 || got.cnt !== cnt0 + 8'd1) begin
            n_fail++;
            $display("FAIL saturation_final: got len=%0d burst=%b cnt=%0d required 15 1 %0d",
                     got.len, got.burst, got.cnt, cnt0 + 8'd1);
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 514; i++) begin
            drive(~i[0], 1'b0);
            got = sample();
            exp = sb.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got %h required %h", i, got, exp);
            end
            if (i == 511) begin
                n_tests++;
                if (got.cnt !== 8'd0 || got.ovf !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wrap_256: got cnt=%0d ovf=%b required cnt=0 ovf=1", got.cnt, got.ovf);
                end
            end
        end
        n_tests++;
        if (got.cnt !== 8'd1 || got.ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_257: got cnt=%0d ovf=%b required cnt=1 ovf=1", got.cnt, got.ovf);
        end
    endtask

    task automatic test_reset_mid();
        // {rst, wr}: two high, reset while high, three high after release, then low
        logic [1:0] seq [7] = '{2'b01, 2'b01, 2'b11, 2'b01, 2'b01, 2'b01, 2'b00};
        foreach (seq[i]) begin
            drive(seq[i][0], seq[i][1]);
            got = sample();
            exp = sb.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: got %h required %h", i, got, exp);
            end
            if (i == 2) begin
                n_tests++;
                if (got !== '0) begin
                    n_fail++;
                    $display("FAIL reset_mid_zero: got %h required 0", got);
                end
            end
            if (i == 3) begin
                n_tests++;
                if (got.rise !== 1'b1 || got.cnt !== 8'd1) begin
                    n_fail++;
                    $display("FAIL reset_mid_rise: got rise=%b cnt=%0d required 1 1", got.rise, got.cnt);
                end
            end
        end
        n_tests++;
        if (got.len !== 4'd3 || got.burst !== 1'b1 || got.fall !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_len: got len=%0d burst=%b fall=%b required 3 1 1",
                     got.len, got.burst, got.fall);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.i_WR = 1'b0;
        m_prev   = 1'b0;
        m_run    = 0;
        m_out    = '0;
        test_reset();
        test_single();
        test_burst();
        test_saturation();
        test_wrap();
        test_reset_mid();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/test_function.md
# test_function

Write-strobe monitor for a single-bit synchronous write request (i_WR). It registers i_WR on every clock edge and produces:
- one-cycle rise and fall pulses;
- a running count of write strobes;
- the length of the most recently completed high pulse;
- a burst flag for pulses at or above a programmable length.

It sits beside a register/FIFO write port as a lightweight observation block and has no effect on the write path itself.

## Interface
Parameters:
- CNT_W, default 8: width of the write-strobe counter.
- LEN_W, default 4: width of the pulse-length measurement.
- BURST_LEN, default 3: minimum completed pulse length (cycles) that sets o_BURST; legal range 1..2^LEN_W-1.

Ports:
- i_CLK  in  1  single clock; all state updates on its rising edge.
- i_RST  in  1  reset, synchronous, active-high; one clock, reset is synchronous and active-high.
- i_WR  in  1  write request, synchronous to i_CLK; the level is sampled each edge.
- o_WR_RISE  out  1  one-cycle pulse: 0→1 transition of i_WR detected.
- o_WR_FALL  out  1  one-cycle pulse: 1→0 transition of i_WR detected.
- o_WR_CNT  out  CNT_W  number of rising edges since reset; wraps.
- o_CNT_OVF  out  1  sticky; set when o_WR_CNT wraps from all-ones to 0.
- o_LAST_LEN  out  LEN_W  length in cycles of the last completed high pulse; saturates.
- o_BURST  out  1  o_LAST_LEN ≥ BURST_LEN; updated on each fall.

## Operation
- S(k) = i_WR sampled at edge k. The internal r_prev holds S(k-1). The internal r_run is the current high-run length, LEN_W bits.
- Rise at edge k: S(k)=1 and r_prev=0.
  - o_WR_RISE <= 1.
  - o_WR_CNT <= o_WR_CNT+1, modulo 2^CNT_W.
  - If the old o_WR_CNT is all-ones, o_CNT_OVF <= 1.
  - r_run <= 1.
- High continues (S(k)=1, r_prev=1): r_run <= r_run+1, saturating at 2^LEN_W-1.
- Fall at edge k: S(k)=0 and r_prev=1.
  - o_WR_FALL <= 1.
  - o_LAST_LEN <= r_run.
  - o_BURST <= (r_run ≥ BURST_LEN).
  - r_run <= 0.
- Otherwise o_WR_RISE and o_WR_FALL <= 0. o_LAST_LEN, o_BURST, o_WR_CNT and o_CNT_OVF hold.
- r_prev <= S(k) every non-reset edge.
- A single-cycle high pulse yields RISE at edge k, FALL at edge k+1, and LAST_LEN=1.
- Back-to-back pulses (1,0,1) are two separate strobes and are counted twice.
- o_CNT_OVF is cleared only by reset.

## Timing
- All outputs are registered, with no combinational path from i_WR to any output.
- Latency: an edge-k event is visible on outputs after edge k, in cycle k..k+1.
  - o_WR_RISE and o_WR_FALL are high for exactly one cycle.
- Reset (i_RST=1 at an edge) has priority over all other logic. After it: r_prev=0, r_run=0, o_WR_RISE=0, o_WR_FALL=0, o_WR_CNT=0, o_CNT_OVF=0, o_LAST_LEN=0, o_BURST=0.
- i_WR is ignored during reset.
- The first edge after reset compares against r_prev=0. If i_WR is high then, a rise is reported; this also applies to a pulse that began during reset.
- Reset mid-pulse discards r_run, and no fall or LAST_LEN update is generated for the aborted pulse.
- Pulses longer than 2^LEN_W-1 report o_LAST_LEN = 2^LEN_W-1 and o_BURST=1.
- i_WR must meet setup/hold to i_CLK; there is no internal synchronizer. Before the first reset, outputs are undefined.

## Test plan
- Reset then idle: hold i_RST=1 for 2 cycles with i_WR=0, release, idle 3 cycles. Required: all outputs 0 throughout.
- Single strobes: i_WR sequence 1,0,1,0 on consecutive edges after reset. Required:
  - RISE at edges 1 and 3; FALL at edges 2 and 4.
  - o_WR_CNT goes 1 then 2.
  - o_LAST_LEN=1 and o_BURST=0 after each fall.
- Burst: continuing after the single strobes, i_WR = 1,1,1,0. Required:
  - o_WR_CNT=3 after the first 1.
  - One FALL pulse at the 0.
  - o_LAST_LEN=3 and o_BURST=1 with BURST_LEN=3.
  - No RISE on the second and third 1.
- Saturation: hold i_WR=1 for 20 cycles, then drop it with LEN_W=4. Required: o_LAST_LEN=15, o_BURST=1, o_WR_CNT incremented by exactly 1.
- Counter wrap: apply 256 single-cycle strobes with CNT_W=8. Required: o_WR_CNT=0 and o_CNT_OVF=1. One more strobe gives o_WR_CNT=1 with o_CNT_OVF still 1.
- Reset mid-pulse: i_WR=1 for 2 cycles, assert i_RST for 1 cycle with i_WR still 1, release. Required:
  - All outputs 0 during reset.
  - RISE on the first edge after release; o_WR_CNT=1.
  - The eventual fall reports the length counted from the release only.
